// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline registers.
// The control bundle width (RESULTSRC_W) must match the RESULTSRC_WIDTH of the registers that use it.
package pipe_pkg;

  localparam int RESULTSRC_W = 2;

  typedef struct packed {
    logic                   RegWrite;
    logic [RESULTSRC_W-1:0] ResultSrc;
    logic                   MemWrite;
    logic                   Jump;
    logic                   JumpReg;
  } ctrl_em_t;

  localparam ctrl_em_t CTRL_EM_BUBBLE = '0;

  localparam int REG_X0 = 0;

  localparam logic [RESULTSRC_W-1:0] RES_ALU = 2'd0;
  localparam logic [RESULTSRC_W-1:0] RES_MEM = 2'd1;
  localparam logic [RESULTSRC_W-1:0] RES_PC4 = 2'd2;

  // Strip side effects from bubbles and from writes aimed at x0.
  function automatic ctrl_em_t gate_ctrl(input ctrl_em_t raw, input logic valid,
                                         input logic rd_nonzero);
    ctrl_em_t g;
    g = CTRL_EM_BUBBLE;
    if (valid) begin
      g          = raw;
      g.RegWrite = raw.RegWrite & rd_nonzero;
    end
    return g;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for pipeline stall/bubble statistics.
module pipe_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall, flush, valid tracking and side-effect gating.
// Optional stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
module ex_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int RESULTSRC_WIDTH = 2,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       StallM,
  input  logic                       FlushM,
  input  logic                       ValidE,
  input  logic [DATA_WIDTH-1:0]      ALUResultE,
  input  logic [DATA_WIDTH-1:0]      WriteDataE,
  input  logic [REG_ADDR_WIDTH-1:0]  RdE,
  input  logic [DATA_WIDTH-1:0]      PCTargetE,
  input  logic [DATA_WIDTH-1:0]      PCPlus4E,
  input  logic                       RegWriteE,
  input  logic [RESULTSRC_WIDTH-1:0] ResultSrcE,
  input  logic                       MemWriteE,
  input  logic                       JumpE,
  input  logic                       JumpRegE,
  output logic                       ValidM,
  output logic [DATA_WIDTH-1:0]      ALUResultM,
  output logic [DATA_WIDTH-1:0]      WriteDataM,
  output logic [DATA_WIDTH-1:0]      PCTargetM,
  output logic [DATA_WIDTH-1:0]      PCPlus4M,
  output logic [REG_ADDR_WIDTH-1:0]  RdM,
  output logic                       RegWriteM,
  output logic                       MemWriteM,
  output logic                       JumpM,
  output logic                       JumpRegM,
  output logic [RESULTSRC_WIDTH-1:0] ResultSrcM
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0]     StallCnt,
  output logic [CNT_WIDTH-1:0]       BubbleCnt
`endif
);

  logic                      valid_q,  valid_d;
  ctrl_em_t                  ctrl_q,   ctrl_d;
  ctrl_em_t                  ctrl_raw;
  logic [DATA_WIDTH-1:0]     alu_q,    alu_d;
  logic [DATA_WIDTH-1:0]     wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0]     target_q, target_d;
  logic [DATA_WIDTH-1:0]     pc4_q,    pc4_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,     rd_d;

  always_comb begin
    ctrl_raw.RegWrite  = RegWriteE;
    ctrl_raw.ResultSrc = RESULTSRC_W'(ResultSrcE);
    ctrl_raw.MemWrite  = MemWriteE;
    ctrl_raw.Jump      = JumpE;
    ctrl_raw.JumpReg   = JumpRegE;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    alu_d    = alu_q;
    wdata_d  = wdata_q;
    target_d = target_q;
    pc4_d    = pc4_q;
    rd_d     = rd_q;
    if (FlushM) begin
      valid_d  = 1'b0;
      ctrl_d   = CTRL_EM_BUBBLE;
      alu_d    = '0;
      wdata_d  = '0;
      target_d = '0;
      pc4_d    = '0;
      rd_d     = '0;
    end else if (!StallM) begin
      valid_d  = ValidE;
      ctrl_d   = gate_ctrl(ctrl_raw, ValidE, RdE != REG_ADDR_WIDTH'(REG_X0));
      alu_d    = ALUResultE;
      wdata_d  = WriteDataE;
      target_d = PCTargetE;
      pc4_d    = PCPlus4E;
      rd_d     = RdE;
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_EM_BUBBLE;
      alu_q    <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      pc4_q    <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
      target_q <= target_d;
      pc4_q    <= pc4_d;
      rd_q     <= rd_d;
    end
  end

  assign ValidM     = valid_q;
  assign ALUResultM = alu_q;
  assign WriteDataM = wdata_q;
  assign PCTargetM  = target_q;
  assign PCPlus4M   = pc4_q;
  assign RdM        = rd_q;
  assign RegWriteM  = ctrl_q.RegWrite;
  assign MemWriteM  = ctrl_q.MemWrite;
  assign JumpM      = ctrl_q.Jump;
  assign JumpRegM   = ctrl_q.JumpReg;
  assign ResultSrcM = RESULTSRC_WIDTH'(ctrl_q.ResultSrc);

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic bubble_inc;

  // A bubble is any edge that leaves ValidM low: a flush, or a load of an invalid EX slot.
  assign stall_inc  = StallM & ~FlushM;
  assign bubble_inc = FlushM | (~StallM & ~ValidE);

  pipe_perf_cnt #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (StallCnt)
  );

  pipe_perf_cnt #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (BubbleCnt)
  );
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Randomized and directed bench for ex_mem_pipe_reg, checked against a behavioural model.
module tb_ex_mem_pipe_reg;
  import pipe_pkg::*;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallM, FlushM, ValidE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, JumpRegE;
  logic [1:0]  ResultSrcE;

  logic        ValidM;
  logic [31:0] ALUResultM, WriteDataM, PCTargetM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM, JumpM, JumpRegM;
  logic [1:0]  ResultSrcM;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] StallCnt, BubbleCnt;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM), .ValidE(ValidE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JumpRegE(JumpRegE),
    .ValidM(ValidM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCTargetM(PCTargetM), .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .JumpM(JumpM), .JumpRegM(JumpRegM), .ResultSrcM(ResultSrcM)
`ifdef PIPE_PERF_CNT_EN
    , .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
`endif
  );

  // Expected MEM-stage contents, derived directly from the stage rules.
  typedef struct {
    logic        valid;
    logic [31:0] alu, wd, pct, pc4;
    logic [4:0]  rd;
    logic        rw, mw, j, jr;
    logic [1:0]  rs;
  } exp_t;

  exp_t m;
  int   stall_n = 0;
  int   bub_n   = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = '{default: 0};
      stall_n = 0;
      bub_n = 0;
    end else if (FlushM) begin
      m = '{default: 0};
      bub_n++;
    end else if (StallM) begin
      stall_n++;
    end else begin
      m.valid = ValidE;
      m.alu = ALUResultE;
      m.wd  = WriteDataE;
      m.pct = PCTargetE;
      m.pc4 = PCPlus4E;
      m.rd  = RdE;
      m.rw  = ValidE && RegWriteE && (RdE != 0);
      m.mw  = ValidE && MemWriteE;
      m.j   = ValidE && JumpE;
      m.jr  = ValidE && JumpRegE;
      m.rs  = ValidE ? ResultSrcE : 2'd0;
      if (!ValidE) bub_n++;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic int sat(input int n);
    return (n > (2**CW - 1)) ? (2**CW - 1) : n;
  endfunction
`endif

  always @(negedge clk) begin
    if (checking) begin
      check("ValidM",     ValidM,     m.valid);
      check("ALUResultM", ALUResultM, m.alu);
      check("WriteDataM", WriteDataM, m.wd);
      check("PCTargetM",  PCTargetM,  m.pct);
      check("PCPlus4M",   PCPlus4M,   m.pc4);
      check("RdM",        RdM,        m.rd);
      check("RegWriteM",  RegWriteM,  m.rw);
      check("MemWriteM",  MemWriteM,  m.mw);
      check("JumpM",      JumpM,      m.j);
      check("JumpRegM",   JumpRegM,   m.jr);
      check("ResultSrcM", ResultSrcM, m.rs);
`ifdef PIPE_PERF_CNT_EN
      check("StallCnt",   StallCnt,   sat(stall_n));
      check("BubbleCnt",  BubbleCnt,  sat(bub_n));
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StallM = 0; FlushM = 0; ValidE = 0;
    ALUResultE = 0; WriteDataE = 0; PCTargetE = 0; PCPlus4E = 0; RdE = 0;
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; JumpRegE = 0; ResultSrcE = RES_ALU;
  endtask

  task automatic random_inputs();
    StallM     = ($urandom_range(0, 3) == 0);
    FlushM     = ($urandom_range(0, 9) == 0);
    ValidE     = ($urandom_range(0, 4) != 0);
    ALUResultE = $urandom;
    WriteDataE = $urandom;
    PCTargetE  = $urandom;
    PCPlus4E   = $urandom;
    RdE        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    RegWriteE  = 1'($urandom);
    MemWriteE  = 1'($urandom);
    JumpE      = 1'($urandom);
    JumpRegE   = 1'($urandom);
    ResultSrcE = 2'($urandom_range(0, 2));
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    checking = 1'b1;

    // Normal load
    ValidE = 1; RdE = 5; RegWriteE = 1; ALUResultE = 32'h10; ResultSrcE = RES_ALU;
    cycle();
    check("load ValidM", ValidM, 1);
    check("load RdM", RdM, 5);
    check("load RegWriteM", RegWriteM, 1);
    check("load ALUResultM", ALUResultM, 32'h10);

    // Write to x0 is suppressed but the index still loads
    RdE = 0;
    cycle();
    check("x0 RegWriteM", RegWriteM, 0);
    check("x0 RdM", RdM, 0);
    check("x0 ValidM", ValidM, 1);

    // Invalid EX slot
    ValidE = 0; MemWriteE = 1; JumpE = 1; JumpRegE = 1; ResultSrcE = RES_MEM; RdE = 9;
    cycle();
    check("inv ValidM", ValidM, 0);
    check("inv MemWriteM", MemWriteM, 0);
    check("inv JumpM", JumpM, 0);
    check("inv ResultSrcM", ResultSrcM, 0);

    // Stall holds, then flush beats stall
    clear_inputs();
    ValidE = 1; ALUResultE = 32'hCAFE0001; RdE = 7; RegWriteE = 1; ResultSrcE = RES_PC4;
    cycle();
    StallM = 1;
    for (int i = 0; i < 3; i++) begin
      ALUResultE = $urandom; RdE = 5'($urandom); ValidE = 1'($urandom); ResultSrcE = RES_MEM;
      cycle();
      check("stall ALUResultM", ALUResultM, 32'hCAFE0001);
      check("stall RdM", RdM, 7);
      check("stall ResultSrcM", ResultSrcM, RES_PC4);
    end
    FlushM = 1;
    cycle();
    check("flush ValidM", ValidM, 0);
    check("flush ALUResultM", ALUResultM, 0);
    check("flush RdM", RdM, 0);
    check("flush RegWriteM", RegWriteM, 0);

    // Asynchronous reset in mid-cycle
    clear_inputs();
    ValidE = 1; ALUResultE = 32'hDEADBEEF; RdE = 3; RegWriteE = 1;
    cycle();
    check("pre-rst ALUResultM", ALUResultM, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ALUResultM", ALUResultM, 0);
    check("async rst ValidM", ValidM, 0);
    check("async rst RegWriteM", RegWriteM, 0);
    StallM = 1; FlushM = 1;
    cycle();
    check("held rst ValidM", ValidM, 0);
    @(negedge clk);
    rst = 1'b0;
    StallM = 0; FlushM = 0; ALUResultE = 32'h55;
    cycle();
    check("post-rst ALUResultM", ALUResultM, 32'h55);
    check("post-rst ValidM", ValidM, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      cycle();
    end

`ifdef PIPE_PERF_CNT_EN
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    StallM = 1;
    for (int i = 0; i < 20; i++) cycle();
    check("StallCnt saturated", StallCnt, 15);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    StallM = 0; ValidE = 1;
    cycle();
    FlushM = 1;
    cycle();
    FlushM = 0; ValidE = 0;
    cycle();
    ValidE = 1; FlushM = 1;
    cycle();
    FlushM = 0;
    cycle();
    check("BubbleCnt", BubbleCnt, 3);
`endif

    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
